// File: rtl/alu_ex_stage.sv
// Execute stage of the RISC-I pipeline: combinational ALU feeding the EX/MEM register.
// Reset clears the register, flush inserts a bubble (and beats stall), stall holds it.
module alu_ex_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned REGW  = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic [3:0]       i_ALUctrl,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [4:0]       i_shamt,
    input  logic [WIDTH-1:0] i_store_data,
    input  logic [REGW-1:0]  i_rd,
    input  logic             i_reg_write,
    input  logic             i_mem_read,
    input  logic             i_mem_write,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_ovf,
    output logic [WIDTH-1:0] o_store_data,
    output logic [REGW-1:0]  o_rd,
    output logic             o_reg_write,
    output logic             o_mem_read,
    output logic             o_mem_write
);

    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SRL  = 4'b1011;
    localparam logic [3:0] OP_XOR  = 4'b1101;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_sra;
    logic             w_slt;
    logic             w_sltu;
    logic [WIDTH-1:0] w_result;
    logic             w_ovf;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
    assign w_sra  = $unsigned($signed(i_b) >>> i_shamt);
    assign w_slt  = $signed(i_a) < $signed(i_b);
    assign w_sltu = i_a < i_b;

    // ALU result and signed overflow; overflow only meaningful for ADD/SUB
    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        case (i_ALUctrl)
            OP_AND:  w_result = i_a & i_b;
            OP_OR:   w_result = i_a | i_b;
            OP_ADD: begin
                w_result = w_sum;
                w_ovf    = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
            end
            OP_SUB: begin
                w_result = w_diff;
                w_ovf    = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
            end
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_slt};
            OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, w_sltu};
            OP_SLL:  w_result = i_b << i_shamt;
            OP_SRL:  w_result = i_b >> i_shamt;
            OP_SRA:  w_result = w_sra;
            OP_XOR:  w_result = i_a ^ i_b;
            default: w_result = '0;
        endcase
    end

    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;
    logic [WIDTH-1:0] r_store_data;
    logic [REGW-1:0]  r_rd;
    logic             r_reg_write;
    logic             r_mem_read;
    logic             r_mem_write;

    // EX/MEM register; a bubble keeps stale data but never any side effect
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_ovf        <= 1'b0;
            r_store_data <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else if (i_flush) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else if (!i_stall) begin
            r_valid      <= i_valid;
            r_result     <= w_result;
            r_zero       <= (w_result == '0);
            r_ovf        <= w_ovf;
            r_store_data <= i_store_data;
            r_rd         <= i_rd;
            r_reg_write  <= i_valid & i_reg_write;
            r_mem_read   <= i_valid & i_mem_read;
            r_mem_write  <= i_valid & i_mem_write;
        end
    end

    assign o_valid      = r_valid;
    assign o_result     = r_result;
    assign o_zero       = r_zero;
    assign o_ovf        = r_ovf;
    assign o_store_data = r_store_data;
    assign o_rd         = r_rd;
    assign o_reg_write  = r_reg_write;
    assign o_mem_read   = r_mem_read;
    assign o_mem_write  = r_mem_write;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed-vector bench for alu_ex_stage: the driver queues the expected EX/MEM contents
// for every edge, and a monitor compares them shortly after that edge.
module tb_alu_ex_stage;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        i_stall;
    logic        i_flush;
    logic [3:0]  i_ALUctrl;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [4:0]  i_shamt;
    logic [31:0] i_store_data;
    logic [4:0]  i_rd;
    logic        i_reg_write;
    logic        i_mem_read;
    logic        i_mem_write;
    logic        o_valid;
    logic [31:0] o_result;
    logic        o_zero;
    logic        o_ovf;
    logic [31:0] o_store_data;
    logic [4:0]  o_rd;
    logic        o_reg_write;
    logic        o_mem_read;
    logic        o_mem_write;

    alu_ex_stage #(.WIDTH(32), .REGW(5)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .i_ALUctrl    (i_ALUctrl),
        .i_a          (i_a),
        .i_b          (i_b),
        .i_shamt      (i_shamt),
        .i_store_data (i_store_data),
        .i_rd         (i_rd),
        .i_reg_write  (i_reg_write),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .o_valid      (o_valid),
        .o_result     (o_result),
        .o_zero       (o_zero),
        .o_ovf        (o_ovf),
        .o_store_data (o_store_data),
        .o_rd         (o_rd),
        .o_reg_write  (o_reg_write),
        .o_mem_read   (o_mem_read),
        .o_mem_write  (o_mem_write)
    );

    localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, SUB = 4'b0110;
    localparam logic [3:0] SLT = 4'b0111, SLTU = 4'b1000, SLL = 4'b1001, SRA = 4'b1010;
    localparam logic [3:0] SRL = 4'b1011, XOR_ = 4'b1101, UND = 4'b0011;

    typedef struct {
        int          tag;
        logic        chk_data;
        logic        valid;
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } exp_t;

    exp_t q[$];
    exp_t last_e;
    int   tag;
    int   checks;
    int   failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int t, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL vec%0d %s got=%h exp=%h", t, nm, got, exp);
        end
    endtask

    // Monitor: one expectation per clock edge, compared 2 time units after it
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("o_valid", e.tag, 32'(o_valid), 32'(e.valid));
                cmp("o_reg_write", e.tag, 32'(o_reg_write), 32'(e.rw));
                cmp("o_mem_read", e.tag, 32'(o_mem_read), 32'(e.mr));
                cmp("o_mem_write", e.tag, 32'(o_mem_write), 32'(e.mw));
                if (e.chk_data) begin
                    cmp("o_result", e.tag, o_result, e.result);
                    cmp("o_zero", e.tag, 32'(o_zero), 32'(e.zero));
                    cmp("o_ovf", e.tag, 32'(o_ovf), 32'(e.ovf));
                    cmp("o_store_data", e.tag, o_store_data, e.sd);
                    cmp("o_rd", e.tag, 32'(o_rd), 32'(e.rd));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input logic r, input logic v, input logic s, input logic f);
        rst = r; i_valid = v; i_stall = s; i_flush = f;
    endtask

    task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh);
        tag++;
        i_ALUctrl = c; i_a = a; i_b = b; i_shamt = sh;
        i_rd = 5'(tag);
        i_store_data = {16'hC0DE, 16'(tag)};
        i_reg_write = 1'b1; i_mem_read = 1'b0; i_mem_write = 1'b0;
    endtask

    task automatic push(input exp_t e);
        last_e = e;
        q.push_back(e);
    endtask

    // Expected entry for a normal load of the currently driven instruction
    task automatic expect_ld(input logic [31:0] r, input logic z, input logic ov);
        exp_t e;
        e.tag = tag; e.chk_data = 1'b1; e.valid = i_valid;
        e.result = r; e.zero = z; e.ovf = ov;
        e.sd = i_store_data; e.rd = i_rd;
        e.rw = i_valid & i_reg_write; e.mr = i_valid & i_mem_read; e.mw = i_valid & i_mem_write;
        push(e);
    endtask

    task automatic expect_zero();
        exp_t e;
        e.tag = tag; e.chk_data = 1'b1; e.valid = 1'b0;
        e.result = '0; e.zero = 1'b0; e.ovf = 1'b0; e.sd = '0; e.rd = '0;
        e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
        push(e);
    endtask

    task automatic expect_bubble();
        exp_t e;
        e = last_e;
        e.tag = tag; e.chk_data = 1'b0; e.valid = 1'b0;
        e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
        push(e);
    endtask

    task automatic expect_hold();
        q.push_back(last_e);
    endtask

    initial begin
        checks = 0; failures = 0; tag = 0;

        // Reset for two cycles with random inputs
        for (int k = 0; k < 2; k++) begin
            ctl(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
            i_ALUctrl = 4'($urandom); i_a = $urandom; i_b = $urandom;
            i_shamt = 5'($urandom); i_store_data = $urandom; i_rd = 5'($urandom);
            i_reg_write = 1'($urandom); i_mem_read = 1'($urandom); i_mem_write = 1'($urandom);
            expect_zero();
            tick();
        end

        ctl(1'b0, 1'b1, 1'b0, 1'b0);
        op(ADD, 32'd5, 32'd7, 5'd0);                      expect_ld(32'd12, 1'b0, 1'b0); tick();
        op(ADD, 32'h7FFFFFFF, 32'd1, 5'd0);               expect_ld(32'h80000000, 1'b0, 1'b1); tick();
        op(SUB, 32'd5, 32'd5, 5'd0);                      expect_ld(32'd0, 1'b1, 1'b0); tick();
        op(SUB, 32'h80000000, 32'd1, 5'd0);               expect_ld(32'h7FFFFFFF, 1'b0, 1'b1); tick();
        op(ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);        expect_ld(32'hFFFFFFFE, 1'b0, 1'b0); tick();
        op(SLT, 32'hFFFFFFFF, 32'd1, 5'd0);               expect_ld(32'd1, 1'b0, 1'b0); tick();
        op(SLTU, 32'hFFFFFFFF, 32'd1, 5'd0);              expect_ld(32'd0, 1'b1, 1'b0); tick();
        op(XOR_, 32'hF0F0F0F0, 32'hFFFF0000, 5'd0);       expect_ld(32'h0F0FF0F0, 1'b0, 1'b0); tick();
        op(AND_, 32'hF0F0F0F0, 32'hFFFF0000, 5'd0);       expect_ld(32'hF0F00000, 1'b0, 1'b0); tick();
        op(OR_, 32'hF0F0F0F0, 32'hFFFF0000, 5'd0);        expect_ld(32'hFFFFF0F0, 1'b0, 1'b0); tick();
        op(UND, 32'h12345678, 32'h9ABCDEF0, 5'd3);        expect_ld(32'd0, 1'b1, 1'b0); tick();
        op(SLL, 32'hDEADBEEF, 32'h80000010, 5'd4);        expect_ld(32'h00000100, 1'b0, 1'b0); tick();
        op(SRL, 32'hDEADBEEF, 32'h80000010, 5'd4);        expect_ld(32'h08000001, 1'b0, 1'b0); tick();
        op(SRA, 32'hDEADBEEF, 32'h80000010, 5'd4);        expect_ld(32'hF8000001, 1'b0, 1'b0); tick();
        op(SLL, 32'hDEADBEEF, 32'h80000010, 5'd0);        expect_ld(32'h80000010, 1'b0, 1'b0); tick();
        op(SRA, 32'hDEADBEEF, 32'h80000010, 5'd0);        expect_ld(32'h80000010, 1'b0, 1'b0); tick();

        // Stall holds the ADD 1+1 entry while upstream presents SUB 9-2
        op(ADD, 32'd1, 32'd1, 5'd0);                      expect_ld(32'd2, 1'b0, 1'b0); tick();
        ctl(1'b0, 1'b1, 1'b1, 1'b0);
        op(SUB, 32'd9, 32'd2, 5'd0);
        for (int k = 0; k < 3; k++) begin
            expect_hold();
            tick();
        end
        ctl(1'b0, 1'b1, 1'b0, 1'b0);                      expect_ld(32'd7, 1'b0, 1'b0); tick();

        // Flush beats stall for a valid store
        ctl(1'b0, 1'b1, 1'b1, 1'b1);
        op(ADD, 32'd100, 32'd8, 5'd0);
        i_reg_write = 1'b0; i_mem_write = 1'b1;
        expect_bubble(); tick();
        // Invalid instruction suppresses its sideband, data still loads
        ctl(1'b0, 1'b0, 1'b0, 1'b0);
        op(ADD, 32'd3, 32'd4, 5'd0);                      expect_ld(32'd7, 1'b0, 1'b0); tick();

        // Back-to-back throughput, one result per cycle
        ctl(1'b0, 1'b1, 1'b0, 1'b0);
        op(ADD, 32'd10, 32'd20, 5'd0);                    expect_ld(32'd30, 1'b0, 1'b0); tick();
        op(SUB, 32'd3, 32'd10, 5'd0);                     expect_ld(32'hFFFFFFF9, 1'b0, 1'b0); tick();
        op(AND_, 32'hFF, 32'h0F, 5'd0);                   expect_ld(32'h0F, 1'b0, 1'b0); tick();
        op(OR_, 32'hF0, 32'h0F, 5'd0);                    expect_ld(32'hFF, 1'b0, 1'b0); tick();
        op(XOR_, 32'hAA, 32'hAA, 5'd0);                   expect_ld(32'd0, 1'b1, 1'b0); tick();
        op(SLT, 32'h80000000, 32'd0, 5'd0);               expect_ld(32'd1, 1'b0, 1'b0); tick();
        op(SLTU, 32'd0, 32'h80000000, 5'd0);              expect_ld(32'd1, 1'b0, 1'b0); tick();
        i_mem_read = 1'b0;
        op(SRL, 32'd0, 32'hFFFFFFFF, 5'd31);
        i_mem_read = 1'b1;                                expect_ld(32'd1, 1'b0, 1'b0); tick();

        // Reset during stall and flush clears; stall after reset keeps zeros
        ctl(1'b1, 1'b1, 1'b1, 1'b1);
        op(ADD, 32'd1, 32'd2, 5'd0);                      expect_zero(); tick();
        ctl(1'b0, 1'b1, 1'b1, 1'b0);                      expect_hold(); tick();
        ctl(1'b0, 1'b1, 1'b0, 1'b0);
        op(ADD, 32'd1, 32'd2, 5'd0);                      expect_ld(32'd3, 1'b0, 1'b0); tick();
        ctl(1'b0, 1'b1, 1'b0, 1'b1);
        op(ADD, 32'd4, 32'd4, 5'd0);                      expect_bubble(); tick();
        ctl(1'b0, 1'b1, 1'b0, 1'b0);
        op(SUB, 32'd0, 32'd1, 5'd0);                      expect_ld(32'hFFFFFFFF, 1'b0, 1'b0); tick();

        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        cmp("queue_drained", 0, 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_ex_stage.md
# alu_ex_stage

Execute-stage datapath block of the pipelined RISC-I core. It consumes the 4-bit ALU control code produced by the ALU control decoder, together with the ID/EX operands and sideband control. It performs the ALU operation and registers the result and control into the EX/MEM pipeline register. Stall holds the register; flush inserts a bubble. The registered zero flag feeds BEQ/BNE resolution.

## Interface
Parameters:
- WIDTH, 32, datapath width of operands and result.
- REGW, 5, register-index width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  EX-stage instruction is valid (0 = bubble).
- i_stall  in  1  hold EX/MEM register contents.
- i_flush  in  1  load a bubble into EX/MEM.
- i_ALUctrl  in  4  ALU operation code from the ALU control decoder.
- i_a  in  WIDTH  operand A (rs, already forwarded).
- i_b  in  WIDTH  operand B (rt or sign-extended immediate, already selected).
- i_shamt  in  5  shift amount for SLL/SRL/SRA.
- i_store_data  in  WIDTH  rt value passed to memory stage for SW.
- i_rd  in  REGW  destination register index.
- i_reg_write, i_mem_read, i_mem_write  in  1 each  sideband control.
- o_valid  out  1  EX/MEM entry valid.
- o_result  out  WIDTH  registered ALU result.
- o_zero  out  1  registered (result == 0).
- o_ovf  out  1  registered signed overflow (ADD/SUB only; else 0).
- o_store_data  out  WIDTH; o_rd  out  REGW.
- o_reg_write, o_mem_read, o_mem_write  out  1 each  registered sideband. When o_valid=0 these are forced to 0.

## Operation
- ALU is combinational on i_a, i_b, i_shamt, i_ALUctrl. Result codes:
  - 0000 AND: a & b.
  - 0001 OR: a | b.
  - 0010 ADD: a + b, mod 2^WIDTH.
  - 0110 SUB: a - b, mod 2^WIDTH.
  - 0111 SLT: signed a<b → 1 else 0, zero-extended.
  - 1000 SLTU: unsigned a<b → 1 else 0.
  - 1001 SLL: b << shamt.
  - 1011 SRL: b >> shamt, logical.
  - 1010 SRA: b >>> shamt, sign-filling.
  - 1101 XOR: a ^ b.
  - Any other code: result 0.
- Shifts use operand B and i_shamt only; i_a is ignored.
- Overflow:
  - ADD: set when a and b have the same sign and the result's sign differs.
  - SUB: set when a and b have different signs and the result's sign differs from a.
  - All other codes: 0.
- Zero flag is computed from the result, not from a==b.
- EX/MEM register update priority per edge:
  - i_rst: all outputs to 0.
  - else i_flush: o_valid=0 and reg_write/mem_read/mem_write=0. Data fields may hold any value; tests must not check them.
  - else i_stall: all outputs hold.
  - else: load. o_valid=i_valid; sideband = i_valid ? inputs : 0; data fields always load.
- Flush overrides a simultaneous stall.
- Stall held for N cycles keeps the same entry for N cycles. The upstream stage is responsible for holding its inputs during the stall.

## Timing
- Latency 1 cycle: inputs sampled at edge k appear on outputs after edge k; no combinational input→output path.
- Reset value of every output is 0, including o_zero. o_zero therefore reads 0 after reset even though the result is 0.
- Reset asserted mid-stall or mid-flush clears the register on that edge. The first load occurs on the first edge with i_rst=0 and i_stall=0.
- Throughput: one instruction per cycle when i_stall=0.

## Test plan
- Reset: assert i_rst for 2 cycles with random inputs → every output 0. Deassert with i_valid=1, ADD, a=5, b=7 → next cycle o_result=12, o_zero=0, o_valid=1.
- Arithmetic edges (one cycle each):
  - ADD 0x7FFFFFFF+1 → 0x80000000, o_ovf=1.
  - SUB 5-5 → 0, o_zero=1, o_ovf=0.
  - SLT 0xFFFFFFFF vs 1 → 1.
  - SLTU 0xFFFFFFFF vs 1 → 0.
  - XOR 0xF0F0F0F0 ^ 0xFFFF0000 → 0x0F0FF0F0.
  - Undefined code 0011 → 0.
- Shifts with b=0x80000010:
  - SLL shamt=4 → 0x00000100.
  - SRL shamt=4 → 0x08000001.
  - SRA shamt=4 → 0xF8000001.
  - shamt=0 → result equals b.
- Stall: load ADD 1+1, then assert i_stall 3 cycles while inputs change to SUB 9-2 → o_result stays 2. On release → o_result=7.
- Flush vs stall: valid SW (mem_write=1) in EX with i_stall=1 and i_flush=1 together → next cycle o_valid=0, o_mem_write=0. Then i_valid=0 with i_reg_write=1 → o_reg_write=0.
- Back-to-back throughput: 8 consecutive valid ops, no stall → 8 consecutive correct outputs, each exactly one cycle after input.
